// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the 2-read/1-write datapath register file.
package regfile_pkg;

    localparam int REG_COUNT = 32;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, R31 forced to zero, optional write-through (REGFILE_BYPASS_EN).
// Zero-cycle latency; no backpressure.
module regfile_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic              fwd_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] rd_dat
);
    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic hit;

`ifdef REGFILE_BYPASS_EN
    // fwd_en already excludes reset and writes aimed at the zero register.
    assign hit = fwd_en && (addr == wr_addr);
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_en, wr_addr, wr_dat};
    assign hit = 1'b0;
`endif

    always_comb begin
        rd_dat = regs[addr];
        if (addr == ZERO_ADDR) begin
            rd_dat = '0;
        end else if (hit) begin
            rd_dat = wr_dat;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32x32 register file, two combinational reads, one synchronous write; R31 reads zero (REGFILE_BYPASS_EN adds write-through).
// Write visible after the edge; reset clears all registers and beats a same-cycle write.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] w_add_i,
    input  logic [DATA_W-1:0] w_dat_i,
    input  logic              write_en_i,
    input  logic [ADDR_W-1:0] a_add_sel,
    input  logic [ADDR_W-1:0] b_add_sel,
    output logic [DATA_W-1:0] r_port_a_o,
    output logic [DATA_W-1:0] r_port_b_o
);
    import regfile_pkg::*;

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_ok;
    logic              fwd_en;

    assign wr_ok  = write_en_i && (w_add_i != ZERO_ADDR);
    assign fwd_en = wr_ok && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[w_add_i] <= w_dat_i;
        end
    end

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .addr    (a_add_sel),
        .regs    (regs),
        .fwd_en  (fwd_en),
        .wr_addr (w_add_i),
        .wr_dat  (w_dat_i),
        .rd_dat  (r_port_a_o)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .addr    (b_add_sel),
        .regs    (regs),
        .fwd_en  (fwd_en),
        .wr_addr (w_add_i),
        .wr_dat  (w_dat_i),
        .rd_dat  (r_port_b_o)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; same-cycle read expectations follow REGFILE_BYPASS_EN.
module tb_register_file;
    import regfile_pkg::*;

    logic      clk_i = 1'b0;
    logic      rst_i;
    reg_addr_t w_add_i;
    reg_data_t w_dat_i;
    logic      write_en_i;
    reg_addr_t a_add_sel;
    reg_addr_t b_add_sel;
    reg_data_t r_port_a_o;
    reg_data_t r_port_b_o;

    int n_checks = 0;
    int n_errors = 0;

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .w_add_i    (w_add_i),
        .w_dat_i    (w_dat_i),
        .write_en_i (write_en_i),
        .a_add_sel  (a_add_sel),
        .b_add_sel  (b_add_sel),
        .r_port_a_o (r_port_a_o),
        .r_port_b_o (r_port_b_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input reg_data_t obs, input reg_data_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, away from sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input reg_addr_t addr, input reg_data_t dat);
        w_add_i    = addr;
        w_dat_i    = dat;
        write_en_i = 1'b1;
        tick();
        write_en_i = 1'b0;
    endtask

    task automatic read_pair(input reg_addr_t aa, input reg_addr_t ba);
        a_add_sel = aa;
        b_add_sel = ba;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < REG_COUNT; i++) begin
            read_pair(reg_addr_t'(i), reg_addr_t'(REG_COUNT - 1 - i));
            check($sformatf("%s_a%0d", tag, i), r_port_a_o, 32'h0);
            check($sformatf("%s_b%0d", tag, REG_COUNT - 1 - i), r_port_b_o, 32'h0);
        end
    endtask

    reg_data_t same_cycle_exp;

    initial begin
        rst_i      = 1'b1;
        w_add_i    = '0;
        w_dat_i    = '0;
        write_en_i = 1'b0;
        a_add_sel  = 5'd31;
        b_add_sel  = 5'd31;
        #1;
        check("pre_reset_r31_a", r_port_a_o, 32'h0);
        check("pre_reset_r31_b", r_port_b_o, 32'h0);
        tick();
        rst_i = 1'b0;
        check_all_zero("reset");

        // Reset clear after preload
        do_write(5'd5, 32'hDEADBEEF);
        read_pair(5'd5, 5'd5);
        check("preload_r5_a", r_port_a_o, 32'hDEADBEEF);
        check("preload_r5_b", r_port_b_o, 32'hDEADBEEF);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        read_pair(5'd5, 5'd5);
        check("clr_r5_a", r_port_a_o, 32'h0);
        check("clr_r5_b", r_port_b_o, 32'h0);
        check_all_zero("clr");

        // Write/read on consecutive edges
        w_add_i = 5'd3; w_dat_i = 32'h12345678; write_en_i = 1'b1;
        tick();
        w_add_i = 5'd7; w_dat_i = 32'hCAFEF00D;
        tick();
        write_en_i = 1'b0;
        read_pair(5'd3, 5'd7);
        check("wr_r3_a", r_port_a_o, 32'h12345678);
        check("wr_r7_b", r_port_b_o, 32'hCAFEF00D);
        read_pair(5'd7, 5'd3);
        check("wr_r7_a", r_port_a_o, 32'hCAFEF00D);
        check("wr_r3_b", r_port_b_o, 32'h12345678);

        // Zero register: write to R31 discarded, neighbour R30 untouched
        do_write(5'd30, 32'h3030_3030);
        w_add_i = 5'd31; w_dat_i = 32'hFFFFFFFF; write_en_i = 1'b1;
        read_pair(5'd31, 5'd31);
        check("r31_fwd_a", r_port_a_o, 32'h0);
        tick();
        write_en_i = 1'b0;
        read_pair(5'd31, 5'd31);
        check("r31_a", r_port_a_o, 32'h0);
        check("r31_b", r_port_b_o, 32'h0);
        read_pair(5'd30, 5'd30);
        check("r30_kept_a", r_port_a_o, 32'h3030_3030);
        check("r30_kept_b", r_port_b_o, 32'h3030_3030);

        // Write-enable gating
        w_add_i = 5'd4; w_dat_i = 32'hAAAA5555; write_en_i = 1'b0;
        tick();
        read_pair(5'd4, 5'd4);
        check("we_gate_r4_a", r_port_a_o, 32'h0);
        check("we_gate_r4_b", r_port_b_o, 32'h0);

        // Reset beats simultaneous write
        rst_i = 1'b1; w_add_i = 5'd9; w_dat_i = 32'h1; write_en_i = 1'b1;
        tick();
        rst_i = 1'b0; write_en_i = 1'b0;
        read_pair(5'd9, 5'd3);
        check("rst_prio_r9", r_port_a_o, 32'h0);
        check("rst_prio_r3", r_port_b_o, 32'h0);

        // Same-cycle read of the address being written
        do_write(5'd2, 32'h11);
        w_add_i = 5'd2; w_dat_i = 32'h22; write_en_i = 1'b1;
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 32'h22;
`else
        same_cycle_exp = 32'h11;
`endif
        read_pair(5'd2, 5'd2);
        check("same_cyc_pre_a", r_port_a_o, same_cycle_exp);
        check("same_cyc_pre_b", r_port_b_o, same_cycle_exp);
        read_pair(5'd2, 5'd3);
        check("same_cyc_other_b", r_port_b_o, 32'h0);
        tick();
        write_en_i = 1'b0;
        read_pair(5'd2, 5'd2);
        check("same_cyc_post_a", r_port_a_o, 32'h22);
        check("same_cyc_post_b", r_port_b_o, 32'h22);

        // Reset suppresses forwarding: stored value shown until the clearing edge
        rst_i = 1'b1; w_add_i = 5'd2; w_dat_i = 32'h33; write_en_i = 1'b1;
        read_pair(5'd2, 5'd2);
        check("rst_nofwd_a", r_port_a_o, 32'h22);
        tick();
        rst_i = 1'b0; write_en_i = 1'b0;
        read_pair(5'd2, 5'd2);
        check("rst_nofwd_post", r_port_a_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
